phoenix_rom_loader: RTL and testbench

Sequences ROM download and core start-up for the Phoenix arcade core. It decodes the HPS ioctl byte stream into write strobes for four ROM regions: program, background chars, foreground chars and colour PROMs. It validates the total byte count, holds the game core in reset until a complete image is present, and releases it after a fixed settle period. It sits between hps_io and the phoenix core, and replaces the ad-hoc `ioctl_download`-based reset OR-ing.

---
 rtl/phoenix_rom_loader.sv | 171 +++++++++++++++++
 tb/tb_phoenix_rom_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phoenix_rom_loader.sv
// phoenix_rom_loader
// Decodes the HPS ioctl byte stream into write strobes for the Phoenix ROM
// regions, validates the downloaded image size and sequences the game core
// reset: held through download, released after a fixed settle period.
module phoenix_rom_loader #(
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned IMG_BYTES   = 25088
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        soft_reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        prog_we,
    output logic        chr_bg_we,
    output logic        chr_fg_we,
    output logic        prom_we,
    output logic [13:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        core_reset,
    output logic        load_ok,
    output logic        load_err,
    output logic [15:0] byte_count
);

    localparam int unsigned CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_NOROM,
        S_LOADING,
        S_SETTLE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic          ovf;
    logic          dl_q;

    logic          sel_prog;
    logic          sel_bg;
    logic          sel_fg;
    logic          sel_prom;
    logic          in_map;
    logic [13:0]   offset;
    logic          dl_rise;
    logic          dl_fall;
    logic          accept;
    logic          acc_map;
    logic          acc_oom;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = dl_q & ~ioctl_download;

    // A byte is taken only inside a download that was entered via a rising
    // edge, so a download left running across a reset stays ignored.
    assign accept  = ioctl_wr & ioctl_download & ((state == S_LOADING) | dl_rise);
    assign acc_map = accept & in_map;
    assign acc_oom = accept & ~in_map;

    // Address map decode: region select and offset within region
    always_comb begin
        sel_prog = 1'b0;
        sel_bg   = 1'b0;
        sel_fg   = 1'b0;
        sel_prom = 1'b0;
        offset   = '0;
        if (ioctl_addr < 25'h4000) begin
            sel_prog = 1'b1;
            offset   = ioctl_addr[13:0];
        end else if (ioctl_addr < 25'h5000) begin
            sel_bg   = 1'b1;
            offset   = {2'b00, ioctl_addr[11:0]};
        end else if (ioctl_addr < 25'h6000) begin
            sel_fg   = 1'b1;
            offset   = {2'b00, ioctl_addr[11:0]};
        end else if (ioctl_addr < 25'h6200) begin
            sel_prom = 1'b1;
            offset   = {5'b00000, ioctl_addr[8:0]};
        end
    end

    assign in_map = sel_prog | sel_bg | sel_fg | sel_prom;

    // Registered write path: one strobe per accepted in-map byte, one cycle later
    always_ff @(posedge clk) begin
        // dl_q tracks the download line even in reset so that a download
        // already in progress does not look like a fresh rising edge.
        dl_q <= ioctl_download;
        if (reset) begin
            prog_we   <= 1'b0;
            chr_bg_we <= 1'b0;
            chr_fg_we <= 1'b0;
            prom_we   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            prog_we   <= accept & sel_prog;
            chr_bg_we <= accept & sel_bg;
            chr_fg_we <= accept & sel_fg;
            prom_we   <= accept & sel_prom;
            if (acc_map) begin
                wr_addr <= offset;
                wr_data <= ioctl_dout;
            end
        end
    end

    // Load/settle/run sequencer with registered status and core reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_NOROM;
            hold_cnt   <= '0;
            ovf        <= 1'b0;
            byte_count <= '0;
            core_reset <= 1'b1;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
        end else if (dl_rise) begin
            state      <= S_LOADING;
            byte_count <= acc_map ? 16'd1 : 16'd0;
            ovf        <= acc_oom;
            core_reset <= 1'b1;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            case (state)
                S_LOADING: begin
                    if (dl_fall) begin
                        if (byte_count == 16'(IMG_BYTES) && !ovf) begin
                            state    <= S_SETTLE;
                            hold_cnt <= HOLD_LOAD;
                            load_ok  <= 1'b1;
                        end else begin
                            state    <= S_ERROR;
                            load_err <= 1'b1;
                        end
                    end else begin
                        if (acc_map && byte_count != '1)
                            byte_count <= byte_count + 16'd1;
                        if (acc_oom)
                            ovf <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (soft_reset) begin
                        hold_cnt <= HOLD_LOAD;
                    end else if (hold_cnt == '0) begin
                        state      <= S_RUN;
                        core_reset <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - CW'(1);
                    end
                end
                S_RUN: begin
                    if (soft_reset) begin
                        state      <= S_SETTLE;
                        hold_cnt   <= HOLD_LOAD;
                        core_reset <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_phoenix_rom_loader.sv
// Directed bench for phoenix_rom_loader. A full-size instance covers the
// real image/settle sizes; a small-image instance sharing the same inputs
// covers the short-image and out-of-map cases cheaply.
module tb_phoenix_rom_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        soft_reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic        prog_we, chr_bg_we, chr_fg_we, prom_we;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        core_reset, load_ok, load_err;
    logic [15:0] byte_count;

    logic        s_prog_we, s_chr_bg_we, s_chr_fg_we, s_prom_we;
    logic [13:0] s_wr_addr;
    logic [7:0]  s_wr_data;
    logic        s_core_reset, s_load_ok, s_load_err;
    logic [15:0] s_byte_count;

    logic [25:0] m_wv;
    logic [25:0] s_wv;
    assign m_wv = {prog_we, chr_bg_we, chr_fg_we, prom_we, wr_addr, wr_data};
    assign s_wv = {s_prog_we, s_chr_bg_we, s_chr_fg_we, s_prom_we, s_wr_addr, s_wr_data};

    phoenix_rom_loader dut (
        .clk            (clk),
        .reset          (reset),
        .soft_reset     (soft_reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .prog_we        (prog_we),
        .chr_bg_we      (chr_bg_we),
        .chr_fg_we      (chr_fg_we),
        .prom_we        (prom_we),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .core_reset     (core_reset),
        .load_ok        (load_ok),
        .load_err       (load_err),
        .byte_count     (byte_count)
    );

    phoenix_rom_loader #(
        .HOLD_CYCLES (4),
        .IMG_BYTES   (6)
    ) dut_s (
        .clk            (clk),
        .reset          (reset),
        .soft_reset     (soft_reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .prog_we        (s_prog_we),
        .chr_bg_we      (s_chr_bg_we),
        .chr_fg_we      (s_chr_fg_we),
        .prom_we        (s_prom_we),
        .wr_addr        (s_wr_addr),
        .wr_data        (s_wr_data),
        .core_reset     (s_core_reset),
        .load_ok        (s_load_ok),
        .load_err       (s_load_err),
        .byte_count     (s_byte_count)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Small-image vectors: address, data, expected {we4, offset, data}
    logic [24:0] t_a [6] = '{25'h0005, 25'h4123, 25'h5FFF, 25'h6000, 25'h61FF, 25'h3FFF};
    logic [7:0]  t_d [6] = '{8'hA1, 8'h5B, 8'hC3, 8'h11, 8'hEE, 8'h7E};
    logic [25:0] t_e [6] = '{{4'b1000, 14'h0005, 8'hA1},
                             {4'b0100, 14'h0123, 8'h5B},
                             {4'b0010, 14'h0FFF, 8'hC3},
                             {4'b0001, 14'h0000, 8'h11},
                             {4'b0001, 14'h01FF, 8'hEE},
                             {4'b1000, 14'h3FFF, 8'h7E}};

    // Full-image region table
    int unsigned r_base [4] = '{32'h0000, 32'h4000, 32'h5000, 32'h6000};
    int unsigned r_size [4] = '{32'h4000, 32'h1000, 32'h1000, 32'h0200};
    logic [3:0]  r_we   [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) tick();
    endtask

    task automatic start_dl;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic end_dl;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic put(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
    endtask

    function automatic logic [7:0] img_byte(input int unsigned a);
        return 8'(a ^ (a >> 8) ^ 32'h5A);
    endfunction

    // Streams all 25088 in-map bytes back to back, checking each strobe
    task automatic full_image(input string tag);
        int unsigned a;
        logic [7:0]  d;
        for (int r = 0; r < 4; r++) begin
            for (int unsigned i = 0; i < r_size[r]; i++) begin
                a = r_base[r] + i;
                d = img_byte(a);
                put(25'(a), d);
                check(tag, 32'(m_wv), 32'({r_we[r], 14'(i), d}));
            end
        end
        ioctl_wr = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        soft_reset     = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ticks(2);

        // Reset state
        check("rst_wv",      32'(m_wv), 32'h0);
        check("rst_core",    32'(core_reset), 32'h1);
        check("rst_ok",      32'(load_ok), 32'h0);
        check("rst_err",     32'(load_err), 32'h0);
        check("rst_cnt",     32'(byte_count), 32'h0);
        check("rst_s_wv",    32'(s_wv), 32'h0);
        reset = 1'b0;
        ticks(2);
        check("norom_core",  32'(core_reset), 32'h1);

        // Short image on the small instance: 5 of 6 bytes
        start_dl();
        for (int i = 0; i < 5; i++) begin
            put(t_a[i], t_d[i]);
            check("short_wr", 32'(s_wv), 32'(t_e[i]));
        end
        end_dl();
        check("short_nostb", 32'(s_wv[25:22]), 32'h0);
        check("short_err",   32'(s_load_err), 32'h1);
        check("short_ok",    32'(s_load_ok), 32'h0);
        check("short_cnt",   32'(s_byte_count), 32'd5);
        check("short_m_err", 32'(load_err), 32'h1);
        ticks(10);
        check("short_core",  32'(s_core_reset), 32'h1);

        // Full small image plus one byte at 0x6200
        start_dl();
        check("oom_clr_err", 32'(s_load_err), 32'h0);
        check("oom_clr_cnt", 32'(s_byte_count), 32'h0);
        for (int i = 0; i < 6; i++) begin
            put(t_a[i], t_d[i]);
            check("oom_wr", 32'(s_wv), 32'(t_e[i]));
        end
        put(25'h6200, 8'h99);
        check("oom_nostb",   32'(s_wv[25:22]), 32'h0);
        end_dl();
        check("oom_cnt",     32'(s_byte_count), 32'd6);
        check("oom_err",     32'(s_load_err), 32'h1);
        check("oom_ok",      32'(s_load_ok), 32'h0);

        // Exact-size small image: settle of 4 cycles
        start_dl();
        for (int i = 0; i < 6; i++) put(t_a[i], t_d[i]);
        end_dl();
        check("sm_ok",       32'(s_load_ok), 32'h1);
        check("sm_err",      32'(s_load_err), 32'h0);
        ticks(3);
        check("sm_hold",     32'(s_core_reset), 32'h1);
        tick();
        check("sm_run",      32'(s_core_reset), 32'h0);

        // Full image on the full-size instance
        start_dl();
        full_image("img1");
        end_dl();
        check("img1_cnt",    32'(byte_count), 32'd25088);
        check("img1_ok",     32'(load_ok), 32'h1);
        check("img1_err",    32'(load_err), 32'h0);
        ticks(1023);
        check("img1_hold",   32'(core_reset), 32'h1);
        tick();
        check("img1_run",    32'(core_reset), 32'h0);
        ticks(3);
        check("idle_nostb",  32'(m_wv[25:22]), 32'h0);

        // Soft reset in RUN: 5-cycle pulse
        soft_reset = 1'b1;
        tick();
        check("soft_core",   32'(core_reset), 32'h1);
        ticks(4);
        soft_reset = 1'b0;
        ticks(1023);
        check("soft_hold",   32'(core_reset), 32'h1);
        check("soft_ok",     32'(load_ok), 32'h1);
        tick();
        check("soft_run",    32'(core_reset), 32'h0);
        check("soft_ok2",    32'(load_ok), 32'h1);

        // Reload while running
        start_dl();
        check("rel_core",    32'(core_reset), 32'h1);
        check("rel_ok",      32'(load_ok), 32'h0);
        check("rel_cnt",     32'(byte_count), 32'h0);
        full_image("img2");
        end_dl();
        check("img2_ok",     32'(load_ok), 32'h1);
        ticks(1024);
        check("img2_run",    32'(core_reset), 32'h0);

        // Reset at the 100th byte of a download
        start_dl();
        for (int unsigned i = 0; i < 99; i++) begin
            put(25'(i), img_byte(i));
            check("pre_rst", 32'(m_wv), 32'({4'b1000, 14'(i), img_byte(i)}));
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd99;
        ioctl_dout = img_byte(99);
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        check("mid_nostb",   32'(m_wv[25:22]), 32'h0);
        check("mid_core",    32'(core_reset), 32'h1);
        check("mid_ok",      32'(load_ok), 32'h0);
        check("mid_cnt",     32'(byte_count), 32'h0);
        for (int unsigned i = 100; i < 110; i++) begin
            put(25'(i), img_byte(i));
            check("post_nostb", 32'(m_wv[25:22]), 32'h0);
        end
        check("post_cnt",    32'(byte_count), 32'h0);
        end_dl();
        check("post_err",    32'(load_err), 32'h0);
        check("post_core",   32'(core_reset), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
